// File: rtl/frame_dispatch_ctrl.sv
// Frame dispatcher: per frame, one metadata beat picks out0/out1, then frame_size bytes pass through
// with generated tkeep/tlast. Optional META_DROP_EN lets md_tdata[1] discard a frame.
module frame_dispatch_ctrl #(
    parameter int DW = 512
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [31:0]       frame_count,
    input  logic [31:0]       frame_size,
    output logic              busy,
    output logic [31:0]       frames_done,
    input  logic [DW-1:0]     axis_md_tdata,
    input  logic              axis_md_tvalid,
    output logic              axis_md_tready,
    input  logic [DW-1:0]     axis_df_tdata,
    input  logic              axis_df_tvalid,
    output logic              axis_df_tready,
    output logic [DW-1:0]     axis_out0_tdata,
    output logic [DW/8-1:0]   axis_out0_tkeep,
    output logic              axis_out0_tlast,
    output logic              axis_out0_tvalid,
    input  logic              axis_out0_tready,
    output logic [DW-1:0]     axis_out1_tdata,
    output logic [DW/8-1:0]   axis_out1_tkeep,
    output logic              axis_out1_tlast,
    output logic              axis_out1_tvalid,
    input  logic              axis_out1_tready
`ifdef META_DROP_EN
    ,
    output logic [31:0]       frames_dropped
`endif
);
    localparam int BPB      = DW / 8;
    localparam int LOG2_BPB = $clog2(BPB);

    typedef enum logic [1:0] {IDLE, META, XFER} state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        md_rdy_q, md_rdy_d;
    logic        dest_q, dest_d;
    logic        drop_q, drop_d;
    logic [31:0] fc_q, fc_d;
    logic [31:0] fs_q, fs_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] done_q, done_d;
`ifdef META_DROP_EN
    logic [31:0] dropped_q, dropped_d;
    logic        unused_md;
    assign unused_md = ^axis_md_tdata[DW-1:2];
`else
    logic        unused_md;
    assign unused_md = ^axis_md_tdata[DW-1:1];
`endif

    logic                xfer, fwd, is_last, sel_rdy, df_hs;
    logic [31:0]         last_idx;
    logic [LOG2_BPB-1:0] rem;
    logic [BPB-1:0]      last_keep, keep;

    // beats-1 computed as (size-1)/BPB so a 2^32-1 byte frame cannot overflow
    assign xfer     = (state_q == XFER);
    assign fwd      = xfer && !drop_q;
    assign last_idx = (fs_q - 32'd1) >> LOG2_BPB;
    assign rem      = fs_q[LOG2_BPB-1:0];
    assign is_last  = (beat_cnt_q == last_idx);

    always_comb begin
        last_keep = '0;
        for (int i = 0; i < BPB; i++)
            last_keep[i] = (rem == '0) || (LOG2_BPB'(i) < rem);
    end

    assign keep    = is_last ? last_keep : '1;
    assign sel_rdy = dest_q ? axis_out1_tready : axis_out0_tready;

    assign axis_df_tready   = xfer && (drop_q || sel_rdy);
    assign df_hs            = axis_df_tvalid && axis_df_tready;
    assign axis_md_tready   = md_rdy_q;
    assign axis_out0_tdata  = axis_df_tdata;
    assign axis_out1_tdata  = axis_df_tdata;
    assign axis_out0_tkeep  = keep;
    assign axis_out1_tkeep  = keep;
    assign axis_out0_tvalid = fwd && !dest_q && axis_df_tvalid;
    assign axis_out1_tvalid = fwd &&  dest_q && axis_df_tvalid;
    assign axis_out0_tlast  = fwd && !dest_q && is_last;
    assign axis_out1_tlast  = fwd &&  dest_q && is_last;
    assign busy             = busy_q;
    assign frames_done      = done_q;
`ifdef META_DROP_EN
    assign frames_dropped   = dropped_q;
`endif

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        dest_d     = dest_q;
        drop_d     = drop_q;
        fc_d       = fc_q;
        fs_d       = fs_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = done_q;
`ifdef META_DROP_EN
        dropped_d  = dropped_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && frame_count != 32'd0 && frame_size != 32'd0) begin
                    fc_d    = frame_count;
                    fs_d    = frame_size;
                    done_d  = 32'd0;
                    busy_d  = 1'b1;
                    state_d = META;
`ifdef META_DROP_EN
                    dropped_d = 32'd0;
`endif
                end
            end
            META: begin
                if (axis_md_tvalid && md_rdy_q) begin
                    dest_d     = axis_md_tdata[0];
`ifdef META_DROP_EN
                    drop_d     = axis_md_tdata[1];
`else
                    drop_d     = 1'b0;
`endif
                    beat_cnt_d = 32'd0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (df_hs) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    if (is_last) begin
                        if (done_q != fc_q)
                            done_d = done_q + 32'd1;
`ifdef META_DROP_EN
                        if (drop_q)
                            dropped_d = dropped_q + 32'd1;
`endif
                        if (done_q + 32'd1 == fc_q) begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = META;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        md_rdy_d = (state_d == META);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            md_rdy_q   <= 1'b0;
            dest_q     <= 1'b0;
            drop_q     <= 1'b0;
            fc_q       <= '0;
            fs_q       <= '0;
            beat_cnt_q <= '0;
            done_q     <= '0;
`ifdef META_DROP_EN
            dropped_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            md_rdy_q   <= md_rdy_d;
            dest_q     <= dest_d;
            drop_q     <= drop_d;
            fc_q       <= fc_d;
            fs_q       <= fs_d;
            beat_cnt_q <= beat_cnt_d;
            done_q     <= done_d;
`ifdef META_DROP_EN
            dropped_q  <= dropped_d;
`endif
        end
    end
endmodule
